atm_session_ctrl: RTL and testbench

Session controller that sequences the atm transaction datapath for one card session: card detect, PIN check with retry limit and lockout, menu/operation dispatch over a req/ack handshake, inactivity timeout, and card eject or capture. It sits between the front-panel inputs and the datapath. The datapath owns the balance arithmetic. This block owns session state and access control only.

---
 rtl/atm_pkg.sv | 19 +
 rtl/atm_timeout_timer.sv | 32 +++
 rtl/atm_session_ctrl.sv | 168 ++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the atm session controller and the datapath.
// Operation codes and session states.
package atm_pkg;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_WDR  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN_WAIT = 3'd1,
    MENU     = 3'd2,
    EXEC     = 3'd3,
    EJECT    = 3'd4,
    LOCKED   = 3'd5
  } state_t;

endpackage

// File: rtl/atm_timeout_timer.sv
// Clear/enable saturating cycle counter with a terminal-count flag.
// Serves both the inactivity timeout and the datapath-ack timeout.
module atm_timeout_timer #(
  parameter int W     = 11,
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  // Count enabled cycles since the last clear, holding at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  // Terminal count: the current cycle is the last one allowed.
  assign tc = (count >= W'(LIMIT - 1));

endmodule

// File: rtl/atm_session_ctrl.sv
// Session controller for one card session: PIN check with lockout, operation
// dispatch to the datapath over req/ack, inactivity timeout, eject/capture.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W          = 4,
  parameter int AMT_W          = 16,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_inserted,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] correct_pin,
  input  logic             op_valid,
  input  logic [1:0]       operation,
  input  logic [AMT_W-1:0] amount,
  input  logic             cancel,
  input  logic             admin_unlock,
  output logic             dp_req,
  output logic [1:0]       dp_operation,
  output logic [AMT_W-1:0] dp_amount,
  input  logic             dp_ack,
  input  logic             dp_success,
  output logic             access_granted,
  output logic             pin_error,
  output logic             txn_done,
  output logic             txn_ok,
  output logic             card_eject,
  output logic             card_capture
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int TRW = $clog2(MAX_TRIES + 1);

  state_t         state;
  state_t         nxt;
  logic [TRW-1:0] tries;
  logic [TRW-1:0] tries_inc;
  logic           pin_ok;
  logic           pin_bad;
  logic           dispatch;
  logic           txn_end;
  logic           tmr_clr;
  logic           tmr_en;
  logic           tmr_tc;

  assign tries_inc = tries + TRW'(1);

  atm_timeout_timer #(.W(TW), .LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // Next-state decode, with input priorities resolved per state.
  always_comb begin
    nxt      = state;
    pin_ok   = 1'b0;
    pin_bad  = 1'b0;
    dispatch = 1'b0;
    txn_end  = 1'b0;
    case (state)
      IDLE: begin
        if (card_inserted) nxt = PIN_WAIT;
        else               nxt = IDLE;
      end
      PIN_WAIT: begin
        if (cancel)              nxt = EJECT;
        else if (!card_inserted) nxt = IDLE;
        else if (pin_valid) begin
          if (pin == correct_pin) begin
            pin_ok = 1'b1;
            nxt    = MENU;
          end else begin
            pin_bad = 1'b1;
            if (tries_inc == TRW'(MAX_TRIES)) nxt = LOCKED;
            else                              nxt = PIN_WAIT;
          end
        end
        else if (tmr_tc)         nxt = EJECT;
        else                     nxt = PIN_WAIT;
      end
      MENU: begin
        if (cancel)              nxt = EJECT;
        else if (!card_inserted) nxt = IDLE;
        else if (op_valid) begin
          if (operation == OP_EXIT) begin
            nxt = EJECT;
          end else begin
            dispatch = 1'b1;
            nxt      = EXEC;
          end
        end
        else if (tmr_tc)         nxt = EJECT;
        else                     nxt = MENU;
      end
      EXEC: begin
        if (dp_ack) begin
          txn_end = 1'b1;
          nxt     = card_inserted ? MENU : IDLE;
        end else if (tmr_tc) begin
          txn_end = 1'b1;
          nxt     = EJECT;
        end else begin
          nxt = EXEC;
        end
      end
      EJECT: begin
        if (!card_inserted) nxt = IDLE;
        else                nxt = EJECT;
      end
      LOCKED: begin
        if (admin_unlock) nxt = IDLE;
        else              nxt = LOCKED;
      end
      default: nxt = IDLE;
    endcase
  end

  // Timer restarts on every state change and on each accepted strobe.
  always_comb begin
    tmr_clr = (nxt != state) || (state == IDLE) || pin_bad || pin_ok || dispatch;
    tmr_en  = (state == PIN_WAIT) || (state == MENU) || (state == EXEC);
  end

  // State register and registered outputs, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tries          <= {TRW{1'b0}};
      dp_req         <= 1'b0;
      dp_operation   <= 2'b00;
      dp_amount      <= {AMT_W{1'b0}};
      access_granted <= 1'b0;
      pin_error      <= 1'b0;
      txn_done       <= 1'b0;
      txn_ok         <= 1'b0;
      card_eject     <= 1'b0;
      card_capture   <= 1'b0;
    end else begin
      state          <= nxt;
      dp_req         <= (nxt == EXEC);
      access_granted <= (nxt == MENU) || (nxt == EXEC);
      card_eject     <= (nxt == EJECT);
      card_capture   <= (nxt == LOCKED);
      pin_error      <= pin_bad && (nxt != LOCKED);
      txn_done       <= txn_end;
      if (txn_end) txn_ok <= dp_ack && dp_success;
      else         txn_ok <= txn_ok;
      if (dispatch) begin
        dp_operation <= operation;
        dp_amount    <= amount;
      end else begin
        dp_operation <= dp_operation;
        dp_amount    <= dp_amount;
      end
      if (state == IDLE || pin_ok) tries <= {TRW{1'b0}};
      else if (pin_bad)            tries <= tries_inc;
      else                         tries <= tries;
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed test-plan scenarios plus randomized
// traffic, all checked every cycle against a session-level behavioural model.
module tb_atm_session_ctrl;

  localparam int PIN_W = 4;
  localparam int AMT_W = 16;
  localparam int MAXT  = 3;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             card_inserted = 1'b0;
  logic [PIN_W-1:0] pin = '0;
  logic             pin_valid = 1'b0;
  logic [PIN_W-1:0] correct_pin = 4'hF;
  logic             op_valid = 1'b0;
  logic [1:0]       operation = 2'b00;
  logic [AMT_W-1:0] amount = '0;
  logic             cancel = 1'b0;
  logic             admin_unlock = 1'b0;
  logic             dp_req;
  logic [1:0]       dp_operation;
  logic [AMT_W-1:0] dp_amount;
  logic             dp_ack = 1'b0;
  logic             dp_success = 1'b0;
  logic             access_granted, pin_error, txn_done, txn_ok, card_eject, card_capture;

  int n_checks = 0;
  int n_fail   = 0;

  atm_session_ctrl #(.PIN_W(PIN_W), .AMT_W(AMT_W), .MAX_TRIES(MAXT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .card_inserted(card_inserted), .pin(pin), .pin_valid(pin_valid),
    .correct_pin(correct_pin), .op_valid(op_valid), .operation(operation), .amount(amount),
    .cancel(cancel), .admin_unlock(admin_unlock), .dp_req(dp_req), .dp_operation(dp_operation),
    .dp_amount(dp_amount), .dp_ack(dp_ack), .dp_success(dp_success),
    .access_granted(access_granted), .pin_error(pin_error), .txn_done(txn_done),
    .txn_ok(txn_ok), .card_eject(card_eject), .card_capture(card_capture)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: which phase the card is in, plus counters and latched data.
  bit             m_in_session, m_authed, m_busy, m_eject, m_locked;
  int             m_wrong, m_quiet;
  bit             m_pin_err, m_done, m_ok;
  logic [1:0]     m_op;
  logic [AMT_W-1:0] m_amt;

  task automatic model_reset();
    m_in_session = 0; m_authed = 0; m_busy = 0; m_eject = 0; m_locked = 0;
    m_wrong = 0; m_quiet = 0; m_pin_err = 0; m_done = 0; m_ok = 0;
    m_op = 2'b00; m_amt = '0;
  endtask

  task automatic go_eject();
    m_in_session = 0; m_authed = 0; m_busy = 0; m_eject = 1;
  endtask

  task automatic go_idle();
    m_in_session = 0; m_authed = 0; m_busy = 0; m_eject = 0;
  endtask

  task automatic model_step();
    bit timed_out;
    bit restart;
    timed_out = (m_quiet == TO - 1);
    restart   = 1;
    m_pin_err = 0;
    m_done    = 0;
    if (m_locked) begin
      if (admin_unlock) m_locked = 0;
    end else if (m_eject) begin
      if (!card_inserted) m_eject = 0;
    end else if (m_busy) begin
      if (dp_ack) begin
        m_done = 1; m_ok = dp_success; m_busy = 0;
        if (!card_inserted) go_idle();
      end else if (timed_out) begin
        m_done = 1; m_ok = 0; go_eject();
      end else restart = 0;
    end else if (m_authed) begin
      if (cancel) go_eject();
      else if (!card_inserted) go_idle();
      else if (op_valid) begin
        if (operation == 2'b11) go_eject();
        else begin m_busy = 1; m_op = operation; m_amt = amount; end
      end else if (timed_out) go_eject();
      else restart = 0;
    end else if (m_in_session) begin
      if (cancel) go_eject();
      else if (!card_inserted) go_idle();
      else if (pin_valid) begin
        if (pin == correct_pin) begin m_authed = 1; m_wrong = 0; end
        else begin
          m_wrong++;
          if (m_wrong == MAXT) begin go_idle(); m_locked = 1; end
          else m_pin_err = 1;
        end
      end else if (timed_out) go_eject();
      else restart = 0;
    end else begin
      if (card_inserted) begin m_in_session = 1; m_wrong = 0; end
    end
    if (restart) m_quiet = 0;
    else         m_quiet = m_quiet + 1;
  endtask

  task automatic compare_all();
    check("cmp_access",   32'(access_granted), 32'(m_authed));
    check("cmp_dp_req",   32'(dp_req),         32'(m_busy));
    check("cmp_eject",    32'(card_eject),     32'(m_eject));
    check("cmp_capture",  32'(card_capture),   32'(m_locked));
    check("cmp_pin_err",  32'(pin_error),      32'(m_pin_err));
    check("cmp_txn_done", 32'(txn_done),       32'(m_done));
    check("cmp_txn_ok",   32'(txn_ok),         32'(m_ok));
    check("cmp_dp_op",    32'(dp_operation),   32'(m_op));
    check("cmp_dp_amt",   32'(dp_amount),      32'(m_amt));
  endtask

  // Per-cycle reference update and comparison just after each rising edge.
  always @(posedge clk) begin
    if (reset) model_reset();
    else begin
      model_step();
      #1;
      compare_all();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe_pin(input logic [PIN_W-1:0] p);
    pin = p; pin_valid = 1'b1; cyc(); pin_valid = 1'b0;
  endtask

  task automatic strobe_op(input logic [1:0] o, input logic [AMT_W-1:0] a);
    operation = o; amount = a; op_valid = 1'b1; cyc(); op_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {23'd0, dp_req, access_granted, pin_error, txn_done, txn_ok,
                           card_eject, card_capture, dp_operation}, 32'd0);
    check({tag, "_amt"}, 32'(dp_amount), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(); cyc();
    check_all_zero("reset");
    reset = 1'b0;
    cyc();

    // Correct PIN
    card_inserted = 1'b1; correct_pin = 4'hF; cyc();
    strobe_pin(4'hF);
    check("grant", 32'(access_granted), 32'd1);
    check("grant_no_err", 32'(pin_error), 32'd0);

    // Deposit, held for three cycles, then successful ack
    strobe_op(2'b01, 16'd500);
    for (int i = 0; i < 3; i++) begin
      check("dep_req", 32'(dp_req), 32'd1);
      check("dep_op", 32'(dp_operation), 32'd1);
      check("dep_amt", 32'(dp_amount), 32'd500);
      cyc();
    end
    dp_ack = 1'b1; dp_success = 1'b1; cyc(); dp_ack = 1'b0;
    check("dep_done", {29'd0, dp_req, txn_done, txn_ok}, 32'h3);
    check("dep_menu", 32'(access_granted), 32'd1);
    cyc();
    check("dep_done_pulse", 32'(txn_done), 32'd0);

    // Failed withdraw, then cancel beats op_valid
    strobe_op(2'b10, 16'd2000);
    cyc();
    dp_ack = 1'b1; dp_success = 1'b0; cyc(); dp_ack = 1'b0;
    check("wdr_ok", 32'(txn_ok), 32'd0);
    check("wdr_access", 32'(access_granted), 32'd1);
    cancel = 1'b1; strobe_op(2'b01, 16'd7); cancel = 1'b0;
    check("cancel_eject", {29'd0, card_eject, dp_req, access_granted}, 32'h4);
    card_inserted = 1'b0; cyc();
    check("eject_idle", 32'(card_eject), 32'd0);

    // Lockout after three wrong PINs
    card_inserted = 1'b1; cyc();
    strobe_pin(4'hA); check("lock_err1", 32'(pin_error), 32'd1);
    cyc();            check("lock_err_pulse", 32'(pin_error), 32'd0);
    strobe_pin(4'hA); check("lock_err2", 32'(pin_error), 32'd1);
    strobe_pin(4'hA);
    check("lock_capture", {29'd0, card_capture, pin_error, access_granted}, 32'h4);
    card_inserted = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(); check("lock_hold", 32'(card_capture), 32'd1); end
    admin_unlock = 1'b1; cyc(); admin_unlock = 1'b0;
    check("unlock", 32'(card_capture), 32'd0);

    // Inactivity timeout in MENU
    card_inserted = 1'b1; cyc();
    strobe_pin(4'hF);
    for (int i = 1; i <= TO; i++) begin
      cyc();
      check("menu_to_eject", 32'(card_eject), (i == TO) ? 32'd1 : 32'd0);
    end
    check("menu_to_access", 32'(access_granted), 32'd0);
    card_inserted = 1'b0; cyc();
    check("menu_to_idle", 32'(card_eject), 32'd0);

    // Datapath never acknowledges
    card_inserted = 1'b1; cyc();
    strobe_pin(4'hF);
    strobe_op(2'b00, 16'd0);
    for (int i = 1; i <= TO; i++) begin
      cyc();
      if (i < TO) check("exec_wait", {30'd0, dp_req, txn_done}, 32'h2);
    end
    check("exec_to", {28'd0, txn_done, txn_ok, dp_req, card_eject}, 32'h9);
    card_inserted = 1'b0; cyc();

    // Reset in the middle of a transaction
    card_inserted = 1'b1; cyc();
    strobe_pin(4'hF);
    strobe_op(2'b10, 16'h1234);
    check("pre_reset_req", 32'(dp_req), 32'd1);
    reset = 1'b1; #1;
    check_all_zero("async_reset");
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("post_reset_done", 32'(txn_done), 32'd0);
    card_inserted = 1'b0; cyc();

    // Randomized traffic in bursts with varying strobe density
    for (int blk = 0; blk < 30; blk++) begin
      int dens;
      dens = $urandom_range(2, 30);
      correct_pin = PIN_W'($urandom);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 99) < 3) card_inserted = ~card_inserted;
        pin          = ($urandom_range(0, 1) == 0) ? correct_pin : PIN_W'($urandom);
        pin_valid    = ($urandom_range(0, 99) < dens);
        op_valid     = ($urandom_range(0, 99) < dens);
        operation    = 2'($urandom);
        amount       = AMT_W'($urandom);
        cancel       = ($urandom_range(0, 99) < 3);
        admin_unlock = ($urandom_range(0, 99) < 5);
        dp_ack       = ($urandom_range(0, 99) < dens);
        dp_success   = 1'($urandom);
        cyc();
      end
    end
    pin_valid = 1'b0; op_valid = 1'b0; cancel = 1'b0; admin_unlock = 1'b0; dp_ack = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
